// File: rtl/othello_io_pkg.sv
// othello_io_pkg
// Shared types and helpers for the host-side I/O path of the solver:
//   result_word_t   - result word as produced by the feed block's output FIFO
//   FRAME_LEN       - bytes per serialized frame
//   DEFAULT_SYNC    - default frame start byte
//   ser_state_t     - result_serializer FSM states
//   frame_checksum  - XOR checksum carried in the last byte of a frame
package othello_io_pkg;

    typedef struct packed {
        logic [7:0]  result;
        logic [15:0] taskid;
    } result_word_t;

    localparam int         FRAME_LEN    = 5;
    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } ser_state_t;

    function automatic logic [7:0] frame_checksum(input result_word_t w);
        return w.taskid[15:8] ^ w.taskid[7:0] ^ w.result;
    endfunction

endpackage

// File: rtl/result_serializer.sv
// result_serializer
// Pops one result word at a time from the feed block's output FIFO and
// streams it to the host link as a 5-byte frame:
//   SYNC_BYTE, taskid[15:8], taskid[7:0], result, checksum
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   fifo_data    result word {result, taskid} from the FIFO
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   one-cycle pop strobe per frame
//   tx_data      frame byte toward the host link
//   tx_valid     tx_data valid (held until accepted)
//   tx_ready     host link accepts the byte this cycle
//   busy         serializer is not idle
//   frame_count  completed frames, wraps silently
module result_serializer
    import othello_io_pkg::*;
#(
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
    parameter int         COUNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [23:0]        fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] frame_count
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    ser_state_t         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [COUNT_W-1:0] count_q, count_d;
    result_word_t       word_q;
    logic [7:0]         csum_q;
    logic               capture;

    // Next-state logic. fifo_rd_en is decoded straight from the IDLE state so
    // a pop is issued in the same cycle fifo_empty is seen low; it is not
    // qualified by reset, so a pop coinciding with reset still reaches the
    // FIFO and that word is dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        capture    = 1'b0;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    // first-word-fall-through: data is already on the bus
                    capture    = (READ_LATENCY == 0);
                    state_d    = S_POP;
                end
            end
            S_POP: begin
                if (READ_LATENCY == 2) begin
                    state_d = S_WAIT;
                end else begin
                    capture = (READ_LATENCY == 1);
                    state_d = S_SEND;
                end
            end
            S_WAIT: begin
                capture = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 3'd0;
                        count_d = count_q + 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Capture register: datapath only, contents are don't-care outside SEND.
    always_ff @(posedge clock) begin
        if (capture) begin
            word_q <= result_word_t'(fifo_data);
            csum_q <= frame_checksum(result_word_t'(fifo_data));
        end
    end

    // Byte mux: forced to zero outside SEND so the bus is quiet when idle.
    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_SEND) begin
            case (idx_q)
                3'd0:    tx_data = SYNC_BYTE;
                3'd1:    tx_data = word_q.taskid[15:8];
                3'd2:    tx_data = word_q.taskid[7:0];
                3'd3:    tx_data = word_q.result;
                3'd4:    tx_data = csum_q;
                default: tx_data = 8'h00;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign frame_count = count_q;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: three instances (read latency 0/1/2), each fed
// by its own FIFO model and watched by its own byte monitor.
module tb_result_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT signals ----------------
    logic [23:0] d0_data, d1_data, d2_data;
    logic        d0_empty, d1_empty, d2_empty;
    logic        d0_rd_en, d1_rd_en, d2_rd_en;
    logic [7:0]  d0_tx_data, d1_tx_data, d2_tx_data;
    logic        d0_tx_valid, d1_tx_valid, d2_tx_valid;
    logic        d0_tx_ready = 1'b0, d1_tx_ready = 1'b0, d2_tx_ready = 1'b0;
    logic        d0_busy, d1_busy, d2_busy;
    logic [3:0]  d0_fc;
    logic [15:0] d1_fc;
    logic [3:0]  d2_fc;

    result_serializer #(.READ_LATENCY(0), .COUNT_W(4)) u_dut0 (
        .clock(clock), .reset(reset), .fifo_data(d0_data), .fifo_empty(d0_empty),
        .fifo_rd_en(d0_rd_en), .tx_data(d0_tx_data), .tx_valid(d0_tx_valid),
        .tx_ready(d0_tx_ready), .busy(d0_busy), .frame_count(d0_fc));

    result_serializer #(.READ_LATENCY(1), .COUNT_W(16)) u_dut1 (
        .clock(clock), .reset(reset), .fifo_data(d1_data), .fifo_empty(d1_empty),
        .fifo_rd_en(d1_rd_en), .tx_data(d1_tx_data), .tx_valid(d1_tx_valid),
        .tx_ready(d1_tx_ready), .busy(d1_busy), .frame_count(d1_fc));

    result_serializer #(.READ_LATENCY(2), .COUNT_W(4)) u_dut2 (
        .clock(clock), .reset(reset), .fifo_data(d2_data), .fifo_empty(d2_empty),
        .fifo_rd_en(d2_rd_en), .tx_data(d2_tx_data), .tx_valid(d2_tx_valid),
        .tx_ready(d2_tx_ready), .busy(d2_busy), .frame_count(d2_fc));

    // ---------------- FIFO models ----------------
    // Data is only meaningful exactly READ_LATENCY cycles after a pop;
    // otherwise the data bus carries random junk.
    logic [23:0] mem0 [0:255];
    logic [23:0] mem1 [0:255];
    logic [23:0] mem2 [0:255];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
    int pops0 = 0, pops1 = 0, pops2 = 0;
    int badpop0 = 0, badpop1 = 0, badpop2 = 0;
    int popc1[$];
    logic [23:0] junk0, s2;

    assign d0_empty = (wr0 == rd0);
    assign d1_empty = (wr1 == rd1);
    assign d2_empty = (wr2 == rd2);
    assign d0_data  = (wr0 != rd0) ? mem0[rd0[7:0]] : junk0;

    always @(posedge clock) begin
        junk0 <= 24'($urandom);
        if (d0_rd_en) begin
            pops0 <= pops0 + 1;
            if (wr0 == rd0) badpop0 <= badpop0 + 1;
            else rd0 <= rd0 + 1;
        end
    end

    always @(posedge clock) begin
        d1_data <= 24'($urandom);
        if (d1_rd_en) begin
            popc1.push_back(cyc);
            pops1 <= pops1 + 1;
            if (wr1 == rd1) badpop1 <= badpop1 + 1;
            else begin
                d1_data <= mem1[rd1[7:0]];
                rd1     <= rd1 + 1;
            end
        end
    end

    always @(posedge clock) begin
        s2      <= 24'($urandom);
        d2_data <= s2;
        if (d2_rd_en) begin
            pops2 <= pops2 + 1;
            if (wr2 == rd2) badpop2 <= badpop2 + 1;
            else begin
                s2  <= mem2[rd2[7:0]];
                rd2 <= rd2 + 1;
            end
        end
    end

    // ---------------- byte monitors (sampled on falling edge) ----------------
    logic [7:0] rx0[$], rx1[$], rx2[$];
    int rxc1[$];
    int vr0[$], vr1[$], vr2[$];
    int viol0 = 0, viol1 = 0, viol2 = 0;
    logic hold0 = 1'b0, hold1 = 1'b0, hold2 = 1'b0;
    logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
    logic [7:0] hd0, hd1, hd2;

    always @(negedge clock) begin
        if (reset) begin
            hold0 <= 1'b0; pv0 <= 1'b0;
        end else begin
            if (hold0 && (!d0_tx_valid || d0_tx_data !== hd0)) viol0 <= viol0 + 1;
            if (d0_tx_valid && !pv0) vr0.push_back(cyc);
            if (d0_tx_valid && d0_tx_ready) rx0.push_back(d0_tx_data);
            hold0 <= d0_tx_valid && !d0_tx_ready; hd0 <= d0_tx_data; pv0 <= d0_tx_valid;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            hold1 <= 1'b0; pv1 <= 1'b0;
        end else begin
            if (hold1 && (!d1_tx_valid || d1_tx_data !== hd1)) viol1 <= viol1 + 1;
            if (d1_tx_valid && !pv1) vr1.push_back(cyc);
            if (d1_tx_valid && d1_tx_ready) begin
                rx1.push_back(d1_tx_data);
                rxc1.push_back(cyc);
            end
            hold1 <= d1_tx_valid && !d1_tx_ready; hd1 <= d1_tx_data; pv1 <= d1_tx_valid;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            hold2 <= 1'b0; pv2 <= 1'b0;
        end else begin
            if (hold2 && (!d2_tx_valid || d2_tx_data !== hd2)) viol2 <= viol2 + 1;
            if (d2_tx_valid && !pv2) vr2.push_back(cyc);
            if (d2_tx_valid && d2_tx_ready) rx2.push_back(d2_tx_data);
            hold2 <= d2_tx_valid && !d2_tx_ready; hd2 <= d2_tx_data; pv2 <= d2_tx_valid;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] frame_byte(input logic [23:0] w, input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'hA5;
            1:       b = w[15:8];
            2:       b = w[7:0];
            3:       b = w[23:16];
            4:       b = w[23:16] ^ w[15:8] ^ w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_mon();
        rx0.delete(); rx1.delete(); rx2.delete();
        rxc1.delete(); vr0.delete(); vr1.delete(); vr2.delete();
        popc1.delete();
    endtask

    task automatic push1(input logic [23:0] w);
        mem1[wr1[7:0]] = w;
        wr1 = wr1 + 1;
    endtask

    task automatic wait_rx1(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx1.size() >= n) break;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({d1_rd_en, d1_tx_valid, d1_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: rd_en/valid/busy=%b expected 000", {d1_rd_en, d1_tx_valid, d1_busy});
        end
        checks++;
        if (d1_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_txdata: got %h expected 00", d1_tx_data);
        end
        checks++;
        if (d1_fc !== 16'd0 || d0_fc !== 4'd0 || d2_fc !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d/%0d expected 0", d0_fc, d1_fc, d2_fc);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({d1_rd_en, d1_tx_valid, d1_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: rd_en/valid/busy=%b expected 000", {d1_rd_en, d1_tx_valid, d1_busy});
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_s [5];
        int p0, k;
        exp_s = '{8'hA5, 8'h12, 8'h34, 8'h3C, 8'h1A};
        do_reset();
        clear_mon();
        d1_tx_ready = 1'b1;
        p0 = pops1;
        push1(24'h3C1234);
        k = cyc;
        wait_rx1(5, 50);
        tick();
        tick();
        checks++;
        if (rx1.size() != 5) begin
            errors++;
            $display("FAIL single_len: got %0d bytes expected 5", rx1.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx1[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h expected %h", i, rx1[i], exp_s[i]);
            end
        end
        checks++;
        if (rxc1[4] - rxc1[0] != 4) begin
            errors++;
            $display("FAIL single_consecutive: span %0d expected 4", rxc1[4] - rxc1[0]);
        end
        checks++;
        if (vr1[0] != k + 2) begin
            errors++;
            $display("FAIL single_latency: first valid cycle %0d expected %0d", vr1[0], k + 2);
        end
        checks++;
        if (pops1 - p0 != 1) begin
            errors++;
            $display("FAIL single_pops: got %0d expected 1", pops1 - p0);
        end
        checks++;
        if (d1_fc !== 16'd1) begin
            errors++;
            $display("FAIL single_count: got %0d expected 1", d1_fc);
        end
        checks++;
        if (d1_busy !== 1'b0 || d1_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b valid=%b expected 0 0", d1_busy, d1_tx_valid);
        end
    endtask

    task automatic test_backpressure();
        int p0, held;
        do_reset();
        clear_mon();
        d1_tx_ready = 1'b1;
        p0 = pops1;
        held = 0;
        push1(24'h3C1234);
        for (int i = 0; i < 40 && rx1.size() < 5; i++) begin
            if (rx1.size() == 2 && held < 3 && d1_tx_valid) begin
                d1_tx_ready = 1'b0;
                held++;
                checks++;
                if (d1_tx_valid !== 1'b1 || d1_tx_data !== 8'h34) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b data=%h expected 1 34", d1_tx_valid, d1_tx_data);
                end
            end else begin
                d1_tx_ready = 1'b1;
            end
            tick();
        end
        d1_tx_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (held != 3 || rx1.size() != 5) begin
            errors++;
            $display("FAIL bp_progress: held=%0d bytes=%0d expected 3 5", held, rx1.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx1[i] !== frame_byte(24'h3C1234, i)) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", i, rx1[i], frame_byte(24'h3C1234, i));
            end
        end
        checks++;
        if (rxc1[2] - rxc1[1] != 4 || rxc1[4] - rxc1[2] != 2) begin
            errors++;
            $display("FAIL bp_timing: gaps %0d,%0d expected 4,2", rxc1[2] - rxc1[1], rxc1[4] - rxc1[2]);
        end
        checks++;
        if (viol1 != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d handshake violations expected 0", viol1);
        end
        checks++;
        if (pops1 - p0 != 1 || d1_fc !== 16'd1) begin
            errors++;
            $display("FAIL bp_pops_count: pops=%0d count=%0d expected 1 1", pops1 - p0, d1_fc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [10];
        int p0;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, 8'hA5, 8'hAB, 8'hCD, 8'hFF, 8'h99};
        do_reset();
        clear_mon();
        d1_tx_ready = 1'b1;
        p0 = pops1;
        push1(24'h010000);
        push1(24'hFFABCD);
        wait_rx1(10, 60);
        tick();
        tick();
        checks++;
        if (rx1.size() != 10) begin
            errors++;
            $display("FAIL b2b_len: got %0d bytes expected 10", rx1.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx1[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, rx1[i], exp_b[i]);
            end
        end
        checks++;
        if (pops1 - p0 != 2) begin
            errors++;
            $display("FAIL b2b_pops: got %0d expected 2", pops1 - p0);
        end
        checks++;
        if (popc1[1] <= rxc1[4] || rxc1[5] != popc1[1] + 2) begin
            errors++;
            $display("FAIL b2b_order: pop2 cycle %0d, frame1 end %0d, frame2 start %0d", popc1[1], rxc1[4], rxc1[5]);
        end
        checks++;
        if (d1_fc !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", d1_fc);
        end
    endtask

    task automatic test_empty();
        int bp0;
        do_reset();
        bp0 = badpop1;
        for (int i = 0; i < 100; i++) begin
            d1_tx_ready = 1'($urandom);
            tick();
            checks++;
            if ({d1_rd_en, d1_tx_valid, d1_busy} !== 3'b000) begin
                errors++;
                $display("FAIL empty_idle: cycle %0d rd_en/valid/busy=%b expected 000", i, {d1_rd_en, d1_tx_valid, d1_busy});
            end
        end
        checks++;
        if (badpop1 != bp0) begin
            errors++;
            $display("FAIL empty_pop: %0d pops while empty expected 0", badpop1 - bp0);
        end
        d1_tx_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [23:0] wa, wb, wc;
        int p0;
        wa = 24'($urandom);
        wb = 24'($urandom);
        wc = 24'($urandom);
        do_reset();
        clear_mon();
        d1_tx_ready = 1'b1;
        p0 = pops1;
        push1(wa);
        push1(wb);
        push1(wc);
        wait_rx1(8, 60);
        checks++;
        if (d1_fc !== 16'd1 || rx1.size() != 8) begin
            errors++;
            $display("FAIL rmid_before: count=%0d bytes=%0d expected 1 8", d1_fc, rx1.size());
        end
        reset = 1'b1;
        d1_tx_ready = 1'b0;
        tick();
        checks++;
        if (d1_tx_valid !== 1'b0 || d1_fc !== 16'd0 || d1_busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: valid=%b count=%0d busy=%b expected 0 0 0", d1_tx_valid, d1_fc, d1_busy);
        end
        reset = 1'b0;
        d1_tx_ready = 1'b1;
        wait_rx1(13, 60);
        tick();
        tick();
        checks++;
        if (rx1.size() != 13) begin
            errors++;
            $display("FAIL rmid_len: got %0d bytes expected 13", rx1.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx1[8 + i] !== frame_byte(wc, i)) begin
                errors++;
                $display("FAIL rmid_next_byte%0d: got %h expected %h", i, rx1[8 + i], frame_byte(wc, i));
            end
        end
        checks++;
        if (pops1 - p0 != 3 || d1_fc !== 16'd1) begin
            errors++;
            $display("FAIL rmid_pops_count: pops=%0d count=%0d expected 3 1", pops1 - p0, d1_fc);
        end
    endtask

    task automatic test_latency_wrap();
        logic [23:0] words [17];
        int p0a, p2a, k, err0, err2;
        bit c15_0, c16_0, c15_2, c16_2;
        c15_0 = 0; c16_0 = 0; c15_2 = 0; c16_2 = 0;
        do_reset();
        clear_mon();
        p0a = pops0;
        p2a = pops2;
        for (int i = 0; i < 17; i++) begin
            words[i] = 24'($urandom);
            mem0[wr0[7:0]] = words[i];
            mem2[wr2[7:0]] = words[i];
            wr0 = wr0 + 1;
            wr2 = wr2 + 1;
        end
        k = cyc;
        for (int i = 0; i < 3000; i++) begin
            if (rx0.size() >= 85 && rx2.size() >= 85) break;
            if (!c15_0 && rx0.size() >= 75) begin
                c15_0 = 1; checks++;
                if (d0_fc !== 4'd15) begin
                    errors++;
                    $display("FAIL lat0_count15: got %0d expected 15", d0_fc);
                end
            end
            if (!c16_0 && rx0.size() >= 80) begin
                c16_0 = 1; checks++;
                if (d0_fc !== 4'd0) begin
                    errors++;
                    $display("FAIL lat0_wrap: got %0d expected 0", d0_fc);
                end
            end
            if (!c15_2 && rx2.size() >= 75) begin
                c15_2 = 1; checks++;
                if (d2_fc !== 4'd15) begin
                    errors++;
                    $display("FAIL lat2_count15: got %0d expected 15", d2_fc);
                end
            end
            if (!c16_2 && rx2.size() >= 80) begin
                c16_2 = 1; checks++;
                if (d2_fc !== 4'd0) begin
                    errors++;
                    $display("FAIL lat2_wrap: got %0d expected 0", d2_fc);
                end
            end
            d0_tx_ready = ($urandom_range(0, 3) != 0);
            d2_tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        d0_tx_ready = 1'b0;
        d2_tx_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (rx0.size() != 85 || rx2.size() != 85) begin
            errors++;
            $display("FAIL sweep_len: got %0d/%0d bytes expected 85", rx0.size(), rx2.size());
        end
        err0 = 0;
        err2 = 0;
        for (int j = 0; j < 85; j++) begin
            if (rx0[j] !== frame_byte(words[j / 5], j % 5)) err0++;
            if (rx2[j] !== frame_byte(words[j / 5], j % 5)) err2++;
        end
        checks++;
        if (err0 != 0) begin
            errors++;
            $display("FAIL lat0_data: %0d wrong bytes expected 0", err0);
        end
        checks++;
        if (err2 != 0) begin
            errors++;
            $display("FAIL lat2_data: %0d wrong bytes expected 0", err2);
        end
        checks++;
        if (d0_fc !== 4'd1 || d2_fc !== 4'd1) begin
            errors++;
            $display("FAIL sweep_count17: got %0d/%0d expected 1", d0_fc, d2_fc);
        end
        checks++;
        if (vr0[0] != k + 2 || vr2[0] != k + 3) begin
            errors++;
            $display("FAIL sweep_latency: first valid %0d/%0d expected %0d/%0d", vr0[0], vr2[0], k + 2, k + 3);
        end
        checks++;
        if (pops0 - p0a != 17 || pops2 - p2a != 17 || badpop0 != 0 || badpop2 != 0) begin
            errors++;
            $display("FAIL sweep_pops: %0d/%0d pops, %0d/%0d while empty, expected 17/17 0/0",
                     pops0 - p0a, pops2 - p2a, badpop0, badpop2);
        end
        checks++;
        if (viol0 != 0 || viol2 != 0) begin
            errors++;
            $display("FAIL sweep_stable: %0d/%0d handshake violations expected 0", viol0, viol2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_empty();
        test_reset_mid();
        test_latency_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Downstream neighbour of the solver feed block. Drains 24-bit result words `{result[7:0], taskid[15:0]}` from the feed's output FIFO.
- Frames each word as a 5-byte packet and streams it over a byte-wide valid/ready interface toward the host link (UART TX / USB bridge).
- One FIFO word in flight at a time; counts completed frames.

Parameters:
- READ_LATENCY, 1, cycles from fifo_rd_en to valid fifo_data; legal values 0 (first-word-fall-through), 1, 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- COUNT_W, 16, width of frame_count.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_data  in  24  result word: [23:16] result, [15:0] taskid.
- fifo_empty  in  1  feed output FIFO empty.
- fifo_rd_en  out  1  pop strobe to feed output FIFO (drives its output_enable).
- tx_data  out  8  byte to host link.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host link accepts byte this cycle.
- busy  out  1  high whenever state is not IDLE.
- frame_count  out  COUNT_W  number of completed frames; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, frame_count=0, byte index=0.
- FSM states: IDLE, POP, WAIT, SEND.
- IDLE:
  - If fifo_empty=0: assert fifo_rd_en for exactly one cycle, go to POP.
  - Never assert fifo_rd_en while fifo_empty=1.
- POP:
  - READ_LATENCY=0: fifo_data was captured in the rd_en cycle; go to SEND.
  - READ_LATENCY=1: capture fifo_data this cycle; go to SEND.
  - READ_LATENCY=2: go to WAIT; capture in WAIT, then go to SEND.
- Capture register: holds taskid and result. Checksum = taskid[15:8] ^ taskid[7:0] ^ result, computed at capture.
- SEND byte order by index 0..4:
  - 0: SYNC_BYTE
  - 1: taskid[15:8]
  - 2: taskid[7:0]
  - 3: result
  - 4: checksum
- Handshake:
  - tx_valid is held high throughout SEND.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - Index advances only on tx_valid & tx_ready.
  - tx_valid never drops without a transfer.
- Frame completion: on the transfer of index 4, frame_count increments, tx_valid drops next cycle, state returns to IDLE. The next pop may occur in the IDLE cycle after completion.
- Latency: fifo_empty falling while IDLE gives first tx_valid 1 + max(READ_LATENCY,1) cycles later. Minimum frame length is 5 cycles with tx_ready held high.
- tx_ready high outside SEND is ignored.
- Exactly one fifo_rd_en pulse per frame; no speculative prefetch.
- Reset mid-frame: frame is aborted, tx_valid drops the next cycle, the popped word is discarded (not re-sent). frame_count is cleared.
- Reset asserted in the same cycle as a pop: the pop still reaches the FIFO; the word is lost. This is the documented behaviour.
- frame_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Unknown state encoding recovers to IDLE.

Decomposition:
- Package `othello_io_pkg`:
  - `result_word_t` packed struct `{logic [7:0] result; logic [15:0] taskid;}`, shared with the feed block's output side.
  - `FRAME_LEN`=5, `DEFAULT_SYNC`=8'hA5.
  - State enum `ser_state_t`.
  - Function `frame_checksum(result_word_t)`.
- No sub-module; the FSM, capture register and byte mux live in one module.

Test Plan:
- Single word, tx_ready=1:
  - Stimulus: fifo_data=24'h3C1234, READ_LATENCY=1.
  - Required: one fifo_rd_en pulse; bytes A5,12,34,3C,1A on consecutive cycles; frame_count=1; busy low afterwards.
- Backpressure:
  - Stimulus: same word; tx_ready low for 3 cycles while index=2.
  - Required: tx_data held at 8'h34 with tx_valid=1 for 4 cycles; remaining bytes 3C,1A follow; no extra pop.
- Back-to-back words:
  - Stimulus: FIFO holds 24'h010000 then 24'hFFABCD.
  - Required: exactly 2 pops, the second only after frame 1 completes; frames A5,00,00,01,01 and A5,AB,CD,FF,99; frame_count=2.
- Empty FIFO:
  - Stimulus: fifo_empty=1 for 100 cycles, tx_ready toggling.
  - Required: fifo_rd_en, tx_valid and busy stay 0.
- Reset mid-frame:
  - Stimulus: assert reset after byte index 2 is transferred.
  - Required: next cycle tx_valid=0, frame_count=0; after release, the next FIFO word is sent from SYNC_BYTE; the aborted word is never sent.
- Latency sweep and wrap:
  - Stimulus: READ_LATENCY 0 and 2 with COUNT_W=4; send 17 frames.
  - Required: captured data correct for both latencies; frame_count reads 0 after frame 16 and 1 after frame 17.
